mc_control_unit: RTL

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control unit: one FSM walks each instruction through
// fetch, decode, execute, memory and writeback, and drives the datapath selects.
module mc_control_unit #(
  parameter int MEM_WAIT = 1,
  parameter int ALUC_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              zero,
  input  logic              lt,
  input  logic              ltu,
  input  logic              mem_ready,
  output logic [2:0]        ImmSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic              AddrSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              illegal,
  output logic              instr_done,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    JALR     = 4'd10,
    JLINK    = 4'd11,
    BRANCH   = 4'd12,
    UPPER    = 4'd13,
    TRAP     = 4'd14
  } state_t;

  typedef struct packed {
    logic [2:0] imm;
    logic [1:0] srcA;
    logic [1:0] srcB;
    logic [1:0] res;
    logic       addr;
    logic [3:0] alu;
    logic       fetch;
    logic       memWrite;
    logic       regWrite;
    logic       pcUncond;
    logic       branch;
    logic       doneUncond;
    logic       trap;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  logic   w_memReady;
  logic   w_taken;
  logic   w_branchIllegal;
  logic   w_unusedFunct7;

  assign w_memReady      = (MEM_WAIT == 0) ? 1'b1 : mem_ready;
  assign w_branchIllegal = (funct3[2:1] == 2'b01);
  assign w_unusedFunct7  = ^{funct7[6], funct7[4:0]};

  // Immediate-form ALU ops ignore funct7[5] except to pick SRA over SRL.
  function automatic logic [3:0] aluOf(input logic [2:0] f3, input logic f7b5,
                                       input logic isImm);
    logic [3:0] sel;
    case (f3)
      3'b000:  sel = (f7b5 && !isImm) ? ALU_SUB : ALU_ADD;
      3'b001:  sel = ALU_SLL;
      3'b010:  sel = ALU_SLT;
      3'b011:  sel = ALU_SLTU;
      3'b100:  sel = ALU_XOR;
      3'b101:  sel = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  sel = ALU_OR;
      default: sel = ALU_AND;
    endcase
    return sel;
  endfunction

  function automatic ctrl_t decodeCtrl(input state_t s, input logic [6:0] opc,
                                       input logic [2:0] f3, input logic f7b5);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.srcB = 2'b10; c.res = 2'b10; c.fetch = 1'b1;
      end
      DECODE: begin
        c.srcA = 2'b01; c.srcB = 2'b01; c.imm = 3'b010;
      end
      MEMADR: begin
        c.srcA = 2'b10; c.srcB = 2'b01;
        c.imm  = (opc == OP_STORE) ? 3'b001 : 3'b000;
      end
      MEMREAD: c.addr = 1'b1;
      MEMWB: begin
        c.res = 2'b01; c.regWrite = 1'b1; c.doneUncond = 1'b1;
      end
      MEMWRITE: begin
        c.addr = 1'b1; c.memWrite = 1'b1;
      end
      EXECR: begin
        c.srcA = 2'b10; c.alu = aluOf(f3, f7b5, 1'b0);
      end
      EXECI: begin
        c.srcA = 2'b10; c.srcB = 2'b01; c.alu = aluOf(f3, f7b5, 1'b1);
      end
      ALUWB: begin
        c.regWrite = 1'b1; c.doneUncond = 1'b1;
      end
      JAL: begin
        c.srcA = 2'b01; c.srcB = 2'b10; c.pcUncond = 1'b1;
      end
      JALR: begin
        c.srcA = 2'b10; c.srcB = 2'b01; c.res = 2'b10; c.pcUncond = 1'b1;
      end
      JLINK: begin
        c.srcA = 2'b01; c.srcB = 2'b10;
      end
      BRANCH: begin
        c.srcA = 2'b10; c.alu = ALU_SUB; c.branch = 1'b1;
      end
      UPPER: begin
        c.srcA = (opc == OP_LUI) ? 2'b11 : 2'b01;
        c.srcB = 2'b01; c.imm = 3'b100;
      end
      TRAP:    c.trap = 1'b1;
      default: c.trap = 1'b1;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:    if (w_memReady) w_next = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = MEMADR;
          OP_RTYPE:          w_next = EXECR;
          OP_ITYPE:          w_next = EXECI;
          OP_BRANCH:         w_next = BRANCH;
          OP_JAL:            w_next = JAL;
          OP_JALR:           w_next = JALR;
          OP_LUI, OP_AUIPC:  w_next = UPPER;
          default:           w_next = TRAP;
        endcase
      end
      MEMADR:   w_next = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (w_memReady) w_next = MEMWB;
      MEMWB:    w_next = FETCH;
      MEMWRITE: if (w_memReady) w_next = FETCH;
      EXECR, EXECI, JAL, JLINK, UPPER: w_next = ALUWB;
      JALR:     w_next = JLINK;
      ALUWB:    w_next = FETCH;
      BRANCH:   w_next = w_branchIllegal ? TRAP : FETCH;
      TRAP:     w_next = TRAP;
      default:  w_next = TRAP;
    endcase
  end

  // Selects are decoded from the state being entered, so they are registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_ctrl  <= decodeCtrl(FETCH, op, funct3, funct7[5]);
    end else begin
      r_state <= w_next;
      r_ctrl  <= decodeCtrl(w_next, op, funct3, funct7[5]);
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      3'b100:  w_taken = lt;
      3'b101:  w_taken = ~lt;
      3'b110:  w_taken = ltu;
      3'b111:  w_taken = ~ltu;
      default: w_taken = 1'b0;
    endcase
  end

  // Enables that wait on memory or branch flags stay combinational; reset masks them all.
  assign IRWrite    = ~rst & r_ctrl.fetch & w_memReady;
  assign PCWrite    = ~rst & ((r_ctrl.fetch & w_memReady) | r_ctrl.pcUncond |
                              (r_ctrl.branch & w_taken & ~w_branchIllegal));
  assign RegWrite   = ~rst & r_ctrl.regWrite;
  assign MemWrite   = ~rst & r_ctrl.memWrite;
  assign illegal    = ~rst & r_ctrl.trap;
  assign instr_done = ~rst & (r_ctrl.doneUncond | (r_ctrl.memWrite & w_memReady) |
                              (r_ctrl.branch & ~w_branchIllegal));

  assign ImmSrc    = r_ctrl.imm;
  assign ALUSrcA   = r_ctrl.srcA;
  assign ALUSrcB   = r_ctrl.srcB;
  assign ResultSrc = r_ctrl.res;
  assign AddrSrc   = r_ctrl.addr;
  assign state     = r_state;

  generate
    if (ALUC_W > 4) begin : g_aluPad
      assign ALUControl = {{(ALUC_W - 4){1'b0}}, r_ctrl.alu};
    end else begin : g_aluNoPad
      assign ALUControl = r_ctrl.alu[ALUC_W-1:0];
    end
  endgenerate

endmodule
